mem_timer: RTL and testbench

- Memory-mapped timer peripheral that sits on the core's data-memory interface as a responder (write port and combinational read port).
- Its interrupt output feeds the core's external interrupt request, making it the source end of the core's interrupt path.
- Provides a prescaled 32-bit up-counter, compare match, one-shot or periodic mode, and a write-1-to-clear pending flag.
- Instantiated beside data RAM. The top-level decoder ORs its rdata_o with the RAM's, gated by address window.

---
 rtl/mem_timer_pkg.sv | 26 ++
 rtl/mem_timer_prescaler.sv | 36 +++
 rtl/mem_timer.sv | 133 +++++++++++++
 tb/tb_mem_timer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_timer_pkg.sv
// ============================================================================
//  Module      : mem_timer_pkg
//  Description : Register offsets, CTRL bit indices and reset constants shared
//                by the memory-mapped timer and its prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_timer_pkg;

  localparam logic [1:0] TMR_CTRL  = 2'h0;
  localparam logic [1:0] TMR_COUNT = 2'h1;
  localparam logic [1:0] TMR_CMP   = 2'h2;
  localparam logic [1:0] TMR_PRESC = 2'h3;

  localparam int EN       = 0;
  localparam int IE       = 1;
  localparam int PERIODIC = 2;
  localparam int PEND     = 3;

  localparam int          PRESC_W = 16;
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mem_timer_prescaler.sv
// ============================================================================
//  Module      : timer_prescaler
//  Description : Free-running divider; asserts tick once every PRESC+1 enabled
//                cycles and restarts on a clear request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler
  import mem_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_psc;

  assign tick = en && (r_psc == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (!en || clr || tick) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_timer.sv
// ============================================================================
//  Module      : mem_timer
//  Description : Data-bus timer peripheral: prescaled 32-bit up-counter with
//                compare match, one-shot/periodic modes and level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timer
  import mem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  output logic        int_o
);

  localparam logic [27:0] c_base_tag = BASE_ADDR[31:4];

  logic               r_en;
  logic               r_ie;
  logic               r_periodic;
  logic               r_pend;
  logic [31:0]        r_count;
  logic [31:0]        r_cmp;
  logic [PRESC_W-1:0] r_presc;

  logic        w_whit, w_rhit;
  logic        w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_presc;
  logic        w_tick, w_tick_eff, w_match;
  logic        w_en_nxt, w_pend_nxt;
  logic [31:0] w_count_nxt;
  logic        w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{waddr_i[1:0], raddr_i[1:0]};

  assign w_whit     = we_i && (waddr_i[31:4] == c_base_tag);
  assign w_rhit     = (raddr_i[31:4] == c_base_tag);
  assign w_wr_ctrl  = w_whit && (waddr_i[3:2] == TMR_CTRL);
  assign w_wr_count = w_whit && (waddr_i[3:2] == TMR_COUNT);
  assign w_wr_cmp   = w_whit && (waddr_i[3:2] == TMR_CMP);
  assign w_wr_presc = w_whit && (waddr_i[3:2] == TMR_PRESC);

  timer_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_en),
    .clr   (w_wr_count || w_wr_presc),
    .presc (r_presc),
    .tick  (w_tick)
  );

  // A software COUNT write owns the cycle: the tick is dropped, no match.
  assign w_tick_eff = w_tick && !w_wr_count;
  assign w_match    = w_tick_eff && (r_count == r_cmp);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_count) begin
      w_count_nxt = wdata_i;
    end else if (w_tick_eff) begin
      w_count_nxt = (w_match && r_periodic) ? 32'd0 : r_count + 32'd1;
    end
  end

  always_comb begin
    w_en_nxt = r_en;
    if (w_wr_ctrl) begin
      w_en_nxt = wdata_i[EN];
    end else if (w_match && !r_periodic) begin
      w_en_nxt = 1'b0;
    end
  end

  // Hardware set beats a same-cycle write-1-to-clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_match) begin
      w_pend_nxt = 1'b1;
    end else if (w_wr_ctrl && wdata_i[PEND]) begin
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_periodic <= 1'b0;
      r_pend     <= 1'b0;
      r_count    <= '0;
      r_cmp      <= CMP_RST;
      r_presc    <= '0;
    end else begin
      r_en    <= w_en_nxt;
      r_pend  <= w_pend_nxt;
      r_count <= w_count_nxt;
      if (w_wr_ctrl) begin
        r_ie       <= wdata_i[IE];
        r_periodic <= wdata_i[PERIODIC];
      end
      if (w_wr_cmp) begin
        r_cmp <= wdata_i;
      end
      if (w_wr_presc) begin
        r_presc <= wdata_i[PRESC_W-1:0];
      end
    end
  end

  assign int_o = r_pend && r_ie;

  always_comb begin
    rdata_o = '0;
    if (w_rhit) begin
      case (raddr_i[3:2])
        TMR_CTRL:  rdata_o = {28'd0, r_pend, r_periodic, r_ie, r_en};
        TMR_COUNT: rdata_o = r_count;
        TMR_CMP:   rdata_o = r_cmp;
        default:   rdata_o = {{(32-PRESC_W){1'b0}}, r_presc};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_timer.sv
// ============================================================================
//  Module      : tb_mem_timer
//  Description : Directed self-checking bench for the mem_timer peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_CTRL  = BASE + 32'h0;
  localparam logic [31:0] A_COUNT = BASE + 32'h4;
  localparam logic [31:0] A_CMP   = BASE + 32'h8;
  localparam logic [31:0] A_PRESC = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] raddr_i = '0;
  logic [31:0] rdata_o;
  logic        int_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_timer #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .raddr_i (raddr_i),
    .rdata_o (rdata_o),
    .int_o   (int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    raddr_i = addr;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  // Write lands on the next rising edge; returns 1ns after it.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we_i    = 1'b1;
    waddr_i = addr;
    wdata_i = data;
    @(posedge clk);
    #1;
    we_i = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_rd("rst_count", A_COUNT, 32'h0);
    chk_rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    chk_rd("rst_presc", A_PRESC, 32'h0);
    chk_rd("rst_outside", BASE + 32'h10, 32'h0);
    chk("rst_int", {31'd0, int_o}, 32'd0);

    wr(32'h2000_0008, 32'h55);
    chk_rd("nohit_wr_cmp", A_CMP, 32'hFFFF_FFFF);
    chk_rd("nohit_rd", 32'h2000_0008, 32'h0);

    // One-shot match at 5
    wr(A_PRESC, 32'd0);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h3);
    cyc(5);
    chk_rd("os_count5", A_COUNT, 32'd5);
    chk("os_int_pre", {31'd0, int_o}, 32'd0);
    cyc(1);
    chk("os_int", {31'd0, int_o}, 32'd1);
    chk_rd("os_ctrl", A_CTRL, 32'hA);
    chk_rd("os_count6", A_COUNT, 32'd6);
    cyc(1);
    chk_rd("os_hold", A_COUNT, 32'd6);

    // Periodic, PRESC=3, CMP=2; upper PRESC bits are dropped
    wr(A_CTRL, 32'h8);
    chk("clr_int", {31'd0, int_o}, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_PRESC, 32'hABCD_0003);
    chk_rd("presc_rd", A_PRESC, 32'h3);
    wr(A_CTRL, 32'h7);
    cyc(3);
    chk_rd("per_c0", A_COUNT, 32'd0);
    cyc(1);
    chk_rd("per_c1", A_COUNT, 32'd1);
    cyc(4);
    chk_rd("per_c2", A_COUNT, 32'd2);
    cyc(3);
    chk_rd("per_c2_hold", A_COUNT, 32'd2);
    chk("per_int_pre", {31'd0, int_o}, 32'd0);
    cyc(1);
    chk_rd("per_wrap0", A_COUNT, 32'd0);
    chk("per_int", {31'd0, int_o}, 32'd1);

    wr(A_CTRL, 32'hF);
    chk("w1c_int", {31'd0, int_o}, 32'd0);
    chk_rd("w1c_ctrl", A_CTRL, 32'h7);
    cyc(10);
    wr(A_CTRL, 32'hF);
    chk("race_int", {31'd0, int_o}, 32'd1);
    chk_rd("race_ctrl", A_CTRL, 32'hF);
    chk_rd("race_count", A_COUNT, 32'd0);

    // Wrap through zero, match at 3, no flag at wrap
    wr(A_CTRL, 32'h8);
    wr(A_PRESC, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    cyc(1);
    chk_rd("wrap_ffff", A_COUNT, 32'hFFFF_FFFF);
    cyc(1);
    chk_rd("wrap_0", A_COUNT, 32'd0);
    chk_rd("wrap_noflag", A_CTRL, 32'h1);
    cyc(1);
    chk_rd("wrap_1", A_COUNT, 32'd1);
    cyc(2);
    chk_rd("wrap_3", A_COUNT, 32'd3);
    cyc(1);
    chk_rd("wrap_pend", A_CTRL, 32'h8);
    chk_rd("wrap_count4", A_COUNT, 32'd4);
    chk("wrap_int_masked", {31'd0, int_o}, 32'd0);

    // COUNT write beats the tick
    wr(A_CTRL, 32'h3);
    chk("mid_int", {31'd0, int_o}, 32'd1);
    wr(A_COUNT, 32'h100);
    chk_rd("cw_wins", A_COUNT, 32'h100);
    cyc(1);
    chk_rd("cw_next", A_COUNT, 32'h101);

    // Asynchronous reset mid-count
    wr(A_COUNT, 32'd7);
    chk_rd("pre_rst_count", A_COUNT, 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_int", {31'd0, int_o}, 32'd0);
    @(negedge clk);
    chk_rd("arst_ctrl", A_CTRL, 32'h0);
    chk_rd("arst_count", A_COUNT, 32'h0);
    chk_rd("arst_cmp", A_CMP, 32'hFFFF_FFFF);
    chk_rd("arst_presc", A_PRESC, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk_rd("post_rst_count", A_COUNT, 32'h0);
    chk_rd("post_rst_ctrl", A_CTRL, 32'h0);
    chk("post_rst_int", {31'd0, int_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
